// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage of an in-order core.
//
// Holds one instruction coming from EX. Loads whose address handshake was
// already accepted by the data SRAM wait here for the response. The load
// result is extracted, then sign- or zero-extended, and passed to WB.
//
// Ports
//   clk, resetn              clock; synchronous active-low reset
//   es_to_ms_valid, es_pc    EX -> MEM handshake and PC
//   es_rf_collect            {we, waddr[4:0], result[31:0]} from EX
//   es_mem_req, es_ld_type   load issued (addr accepted) and load flavour
//   es_vaddr, es_except      access address and {ale,adef,ine,sys,brk,int,ertn}
//   data_sram_data_ok/rdata  load response strobe and data
//   ws_allowin, wb_flush     WB back-pressure and pipeline flush
//   ms_allowin               MEM can accept from EX
//   ms_to_ws_valid, ms_pc    MEM -> WB handshake and PC
//   ms_rf_collect            {we, waddr, wdata} towards the register file
//   ms_to_ws_bus, ms_vaddr   latched exception vector and address
//   ms_ex_flag               valid excepting/ertn instruction in MEM
//   ms_ld_pending            valid load still waiting for its data
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_to_ms_valid,
  input  logic [31:0] es_pc,
  input  logic [37:0] es_rf_collect,
  input  logic        es_mem_req,
  input  logic [2:0]  es_ld_type,
  input  logic [31:0] es_vaddr,
  input  logic [6:0]  es_except,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allowin,
  input  logic        wb_flush,
  output logic        ms_allowin,
  output logic        ms_to_ws_valid,
  output logic [31:0] ms_pc,
  output logic [37:0] ms_rf_collect,
  output logic [6:0]  ms_to_ws_bus,
  output logic [31:0] ms_vaddr,
  output logic        ms_ex_flag,
  output logic        ms_ld_pending
);

  // Response tracking: Wait = outstanding, Hold = buffered because WB stalled,
  // Drop = instruction flushed but its response is still on the way.
  typedef enum logic [1:0] {StIdle, StWait, StHold, StDrop} state_e;

  state_e      state_q;
  logic        ms_valid_q;
  logic [31:0] pc_q;
  logic [37:0] rf_q;
  logic [2:0]  ld_type_q;
  logic [31:0] vaddr_q;
  logic [6:0]  except_q;
  logic        mem_req_q;
  logic [31:0] buf_q;

  logic        ms_has_ex;
  logic        ms_ready_go;
  logic        latch;
  logic        new_load;
  logic [31:0] raw;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign ms_has_ex = |except_q;

  always_comb begin
    ms_ready_go = 1'b0;
    case (state_q)
      StIdle:  ms_ready_go = 1'b1;
      StWait:  ms_ready_go = data_sram_data_ok;
      StHold:  ms_ready_go = 1'b1;
      default: ms_ready_go = 1'b0;
    endcase
  end

  assign ms_allowin     = (~ms_valid_q | (ms_ready_go & ws_allowin)) & (state_q != StDrop);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go & ~wb_flush;

  assign latch    = es_to_ms_valid & ms_allowin;
  // Excepting loads never had a request issued, so nothing to wait for.
  assign new_load = latch & es_mem_req & ~(|es_except);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      ms_valid_q <= 1'b0;
      pc_q       <= '0;
      rf_q       <= '0;
      ld_type_q  <= '0;
      vaddr_q    <= '0;
      except_q   <= '0;
      mem_req_q  <= 1'b0;
      buf_q      <= '0;
    end else begin
      if (wb_flush) begin
        ms_valid_q <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid_q <= es_to_ms_valid;
      end

      if (latch) begin
        pc_q      <= es_pc;
        rf_q      <= es_rf_collect;
        ld_type_q <= es_ld_type;
        vaddr_q   <= es_vaddr;
        except_q  <= es_except;
        mem_req_q <= es_mem_req;
      end

      case (state_q)
        StIdle: begin
          if (!wb_flush && new_load) state_q <= StWait;
        end
        StWait: begin
          if (wb_flush) begin
            // A response arriving with the flush is simply discarded.
            state_q <= data_sram_data_ok ? StIdle : StDrop;
          end else if (data_sram_data_ok) begin
            if (ws_allowin) begin
              state_q <= new_load ? StWait : StIdle;
            end else begin
              buf_q   <= data_sram_rdata;
              state_q <= StHold;
            end
          end
        end
        StHold: begin
          if (wb_flush) begin
            state_q <= StIdle;
          end else if (ws_allowin) begin
            state_q <= new_load ? StWait : StIdle;
          end
        end
        StDrop: begin
          if (data_sram_data_ok) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign raw     = (state_q == StHold) ? buf_q : data_sram_rdata;
  assign ld_half = vaddr_q[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    ld_byte = raw[7:0];
    case (vaddr_q[1:0])
      2'd0:    ld_byte = raw[7:0];
      2'd1:    ld_byte = raw[15:8];
      2'd2:    ld_byte = raw[23:16];
      default: ld_byte = raw[31:24];
    endcase
  end

  always_comb begin
    ld_data = raw;
    case (ld_type_q)
      3'b001:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  ld_data = {24'b0, ld_byte};
      3'b011:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {16'b0, ld_half};
      default: ld_data = raw;
    endcase
  end

  assign ms_rf_collect = {rf_q[37] & ms_valid_q & ~ms_has_ex,
                          rf_q[36:32],
                          mem_req_q ? ld_data : rf_q[31:0]};
  assign ms_pc         = pc_q;
  assign ms_vaddr      = vaddr_q;
  assign ms_to_ws_bus  = except_q;
  assign ms_ex_flag    = ms_valid_q & ms_has_ex;
  assign ms_ld_pending = ms_valid_q & mem_req_q & ~ms_has_ex & (state_q == StWait) &
                         ~data_sram_data_ok;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        es_to_ms_valid;
  logic [31:0] es_pc;
  logic [37:0] es_rf_collect;
  logic        es_mem_req;
  logic [2:0]  es_ld_type;
  logic [31:0] es_vaddr;
  logic [6:0]  es_except;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        wb_flush;
  logic        ms_allowin;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [37:0] ms_rf_collect;
  logic [6:0]  ms_to_ws_bus;
  logic [31:0] ms_vaddr;
  logic        ms_ex_flag;
  logic        ms_ld_pending;

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .es_to_ms_valid   (es_to_ms_valid),
    .es_pc            (es_pc),
    .es_rf_collect    (es_rf_collect),
    .es_mem_req       (es_mem_req),
    .es_ld_type       (es_ld_type),
    .es_vaddr         (es_vaddr),
    .es_except        (es_except),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata  (data_sram_rdata),
    .ws_allowin       (ws_allowin),
    .wb_flush         (wb_flush),
    .ms_allowin       (ms_allowin),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ms_pc            (ms_pc),
    .ms_rf_collect    (ms_rf_collect),
    .ms_to_ws_bus     (ms_to_ws_bus),
    .ms_vaddr         (ms_vaddr),
    .ms_ex_flag       (ms_ex_flag),
    .ms_ld_pending    (ms_ld_pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: the instruction held in MEM plus what we know about its data.
  logic        m_valid, m_mem_req, m_got, m_orphan;
  logic [31:0] m_pc, m_vaddr, m_buf;
  logic [37:0] m_rf;
  logic [2:0]  m_ld_type;
  logic [6:0]  m_except;
  // Expected values for the current cycle.
  logic        e_has_ex, e_waiting, e_ready_go, e_allowin, e_tws_valid, e_pld, e_ex_flag;
  logic [31:0] e_wdata;

  // Memory-side response scheduler used by the random phase.
  logic        rp;
  int unsigned dly;

  function automatic logic [31:0] load_value(input logic [2:0] t, input logic [1:0] off,
                                             input logic [31:0] raw);
    logic [31:0] b, h;
    b = (raw >> (8 * off)) & 32'hff;
    h = (raw >> (16 * off[1])) & 32'hffff;
    case (t)
      3'd1:    return (b >= 32'd128) ? b + 32'hffff_ff00 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'd32768) ? h + 32'hffff_0000 : h;
      3'd4:    return h;
      default: return raw;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    resetn            = 1'b1;
    es_to_ms_valid    = 1'b0;
    es_pc             = '0;
    es_rf_collect     = '0;
    es_mem_req        = 1'b0;
    es_ld_type        = '0;
    es_vaddr          = '0;
    es_except         = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    ws_allowin        = 1'b1;
    wb_flush          = 1'b0;
  endtask

  task automatic issue(input logic [2:0] t, input logic [31:0] va, input logic [6:0] ex,
                       input logic [37:0] rf);
    set_idle();
    es_to_ms_valid = 1'b1;
    es_mem_req     = 1'b1;
    es_ld_type     = t;
    es_vaddr       = va;
    es_except      = ex;
    es_rf_collect  = rf;
    es_pc          = va + 32'h4000;
  endtask

  // Let inputs settle, compute the expectation and compare every output.
  task automatic eval();
    #1;
    e_has_ex    = (m_except != 7'd0);
    e_waiting   = m_valid && m_mem_req && !e_has_ex && !m_got;
    e_ready_go  = m_orphan ? 1'b0 : (e_waiting ? data_sram_data_ok : 1'b1);
    e_allowin   = (!m_valid || (e_ready_go && ws_allowin)) && !m_orphan;
    e_tws_valid = m_valid && e_ready_go && !wb_flush;
    e_pld       = e_waiting && !data_sram_data_ok;
    e_ex_flag   = m_valid && e_has_ex;
    e_wdata     = m_mem_req ? load_value(m_ld_type, m_vaddr[1:0],
                                         m_got ? m_buf : data_sram_rdata) : m_rf[31:0];
    check("allowin", 64'(ms_allowin), 64'(e_allowin));
    check("to_ws_valid", 64'(ms_to_ws_valid), 64'(e_tws_valid));
    check("ex_flag", 64'(ms_ex_flag), 64'(e_ex_flag));
    check("ld_pending", 64'(ms_ld_pending), 64'(e_pld));
    check("pc", 64'(ms_pc), 64'(m_pc));
    check("vaddr", 64'(ms_vaddr), 64'(m_vaddr));
    check("to_ws_bus", 64'(ms_to_ws_bus), 64'(m_except));
    check("rf_we", 64'(ms_rf_collect[37]), 64'(m_rf[37] && m_valid && !e_has_ex));
    check("rf_waddr", 64'(ms_rf_collect[36:32]), 64'(m_rf[36:32]));
    if (!m_mem_req || (e_tws_valid && !e_has_ex))
      check("rf_wdata", 64'(ms_rf_collect[31:0]), 64'(e_wdata));
  endtask

  task automatic model_seq();
    logic lat;
    if (!resetn) begin
      m_valid = 0; m_mem_req = 0; m_got = 0; m_orphan = 0;
      m_pc = 0; m_vaddr = 0; m_buf = 0; m_rf = 0; m_ld_type = 0; m_except = 0;
    end else begin
      lat = es_to_ms_valid && e_allowin;
      if (wb_flush) begin
        if (e_waiting && !data_sram_data_ok) m_orphan = 1;
        else if (m_orphan && data_sram_data_ok) m_orphan = 0;
        m_valid = 0;
        m_got   = 0;
      end else begin
        if (m_orphan) begin
          if (data_sram_data_ok) m_orphan = 0;
        end else if (e_waiting && data_sram_data_ok && !ws_allowin) begin
          m_got = 1;
          m_buf = data_sram_rdata;
        end
        if (e_allowin) begin
          m_valid = es_to_ms_valid;
          m_got   = 0;
        end
      end
      if (lat) begin
        m_pc = es_pc; m_rf = es_rf_collect; m_ld_type = es_ld_type;
        m_vaddr = es_vaddr; m_except = es_except; m_mem_req = es_mem_req;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    model_seq();
    @(negedge clk);
  endtask

  initial begin
    logic issue_req, done, rst_now;
    logic [6:0] exv;
    set_idle();
    resetn = 1'b0;
    adv();
    adv();

    // Reset state.
    set_idle();
    eval();
    check("rst_allowin", 64'(ms_allowin), 64'd1);
    check("rst_tws", 64'(ms_to_ws_valid), 64'd0);
    check("rst_ex", 64'(ms_ex_flag), 64'd0);
    check("rst_pld", 64'(ms_ld_pending), 64'd0);
    adv();

    // ALU result passes straight through.
    set_idle();
    es_to_ms_valid = 1'b1;
    es_pc          = 32'h100;
    es_rf_collect  = {1'b1, 5'd5, 32'h1234_5678};
    eval();
    adv();
    set_idle();
    eval();
    check("alu_tws", 64'(ms_to_ws_valid), 64'd1);
    check("alu_rf", 64'(ms_rf_collect), 64'({1'b1, 5'd5, 32'h1234_5678}));
    adv();

    // ld.b at offset 3 with a two-cycle response delay.
    issue(3'd1, 32'h1003, 7'd0, {1'b1, 5'd6, 32'd0});
    eval();
    adv();
    set_idle();
    eval();
    check("ldb_pld1", 64'(ms_ld_pending), 64'd1);
    check("ldb_tws1", 64'(ms_to_ws_valid), 64'd0);
    adv();
    eval();
    check("ldb_pld2", 64'(ms_ld_pending), 64'd1);
    adv();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_0000;
    eval();
    check("ldb_tws", 64'(ms_to_ws_valid), 64'd1);
    check("ldb_data", 64'(ms_rf_collect[31:0]), 64'h0000_0000_FFFF_FF80);
    adv();
    set_idle();
    eval();
    adv();

    // ld.hu upper half.
    issue(3'd4, 32'h2002, 7'd0, {1'b1, 5'd9, 32'd0});
    eval();
    adv();
    set_idle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_0000;
    eval();
    check("ldhu_data", 64'(ms_rf_collect[31:0]), 64'h0000_80FF);
    adv();
    set_idle();
    eval();
    adv();

    // Response while WB stalls for three cycles: buffered and delivered once.
    issue(3'd0, 32'h3000, 7'd0, {1'b1, 5'd7, 32'd0});
    eval();
    adv();
    set_idle();
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    eval();
    check("hold_tws0", 64'(ms_to_ws_valid), 64'd1);
    check("hold_allowin0", 64'(ms_allowin), 64'd0);
    adv();
    for (int i = 0; i < 2; i++) begin
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h1111_1111;
      ws_allowin        = 1'b0;
      eval();
      check("hold_tws", 64'(ms_to_ws_valid), 64'd1);
      check("hold_allowin", 64'(ms_allowin), 64'd0);
      check("hold_data", 64'(ms_rf_collect[31:0]), 64'hDEAD_BEEF);
      adv();
    end
    ws_allowin = 1'b1;
    eval();
    check("hold_rel_tws", 64'(ms_to_ws_valid), 64'd1);
    check("hold_rel_data", 64'(ms_rf_collect[31:0]), 64'hDEAD_BEEF);
    adv();
    set_idle();
    eval();
    check("hold_once", 64'(ms_to_ws_valid), 64'd0);
    adv();

    // Flush while waiting: orphan response is swallowed.
    issue(3'd0, 32'h4000, 7'd0, {1'b1, 5'd8, 32'd0});
    eval();
    adv();
    set_idle();
    wb_flush = 1'b1;
    eval();
    check("flush_tws", 64'(ms_to_ws_valid), 64'd0);
    adv();
    set_idle();
    eval();
    check("drop_allowin", 64'(ms_allowin), 64'd0);
    check("drop_tws", 64'(ms_to_ws_valid), 64'd0);
    adv();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5555_AAAA;
    eval();
    check("drop_ok_allowin", 64'(ms_allowin), 64'd0);
    check("drop_ok_tws", 64'(ms_to_ws_valid), 64'd0);
    adv();
    set_idle();
    eval();
    check("drop_done_allowin", 64'(ms_allowin), 64'd1);
    adv();

    // Misaligned load: no wait, exception reported.
    issue(3'd0, 32'h5001, 7'b1000000, {1'b1, 5'd10, 32'd0});
    eval();
    adv();
    set_idle();
    eval();
    check("ale_ex", 64'(ms_ex_flag), 64'd1);
    check("ale_we", 64'(ms_rf_collect[37]), 64'd0);
    check("ale_bus", 64'(ms_to_ws_bus), 64'b1000000);
    check("ale_tws", 64'(ms_to_ws_valid), 64'd1);
    check("ale_pld", 64'(ms_ld_pending), 64'd0);
    adv();

    // Reset while holding buffered data.
    issue(3'd0, 32'h6000, 7'd0, {1'b1, 5'd11, 32'd0});
    eval();
    adv();
    set_idle();
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0BAD_F00D;
    eval();
    adv();
    set_idle();
    ws_allowin = 1'b0;
    resetn     = 1'b0;
    eval();
    adv();
    set_idle();
    data_sram_data_ok = 1'b1;
    eval();
    check("rst2_tws", 64'(ms_to_ws_valid), 64'd0);
    check("rst2_allowin", 64'(ms_allowin), 64'd1);
    check("rst2_ex", 64'(ms_ex_flag), 64'd0);
    check("rst2_pld", 64'(ms_ld_pending), 64'd0);
    check("rst2_pc", 64'(ms_pc), 64'd0);
    adv();

    // Random traffic against the model.
    rp  = 1'b0;
    dly = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      set_idle();
      resetn     = ($urandom_range(0, 199) != 0);
      ws_allowin = ($urandom_range(0, 9) < 7);
      wb_flush   = ($urandom_range(0, 19) == 0);
      if (!wb_flush && $urandom_range(0, 9) < 6) begin
        es_to_ms_valid = 1'b1;
        es_mem_req     = $urandom_range(0, 1) == 1;
        es_ld_type     = 3'($urandom_range(0, 4));
        es_vaddr       = $urandom;
        es_pc          = $urandom;
        es_rf_collect  = {6'($urandom), 32'($urandom)};
        exv            = 7'd1 << $urandom_range(0, 6);
        es_except      = ($urandom_range(0, 7) == 0) ? exv : 7'd0;
      end
      data_sram_rdata   = $urandom;
      data_sram_data_ok = rp ? (dly == 0) : ($urandom_range(0, 9) == 0);
      eval();
      rst_now   = !resetn;
      done      = rp && data_sram_data_ok;
      issue_req = es_to_ms_valid && e_allowin && es_mem_req && (es_except == 7'd0);
      adv();
      if (rst_now) begin
        rp = 1'b0;
      end else begin
        if (done) rp = 1'b0;
        else if (rp && dly > 0) dly--;
        if (issue_req) begin
          rp  = 1'b1;
          dly = $urandom_range(0, 3);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
